refresh_scheduler: RTL
======================

Name: refresh_scheduler

Overview:
- Periodic refresh scheduler for the DDR controller. Sits directly downstream of the interval counter_up instance: it consumes the counter's count and drives the counter's up and reset inputs.
- Converts elapsed tREFI intervals into a count of owed refreshes.
- Presents owed refreshes to the command arbiter through a req/ack handshake, with an urgency flag and a sticky overflow flag.

Parameters:
- CNT_WIDTH_P, 16, width of count_i; must hold TREFI_P-1.
- TREFI_P, 7800, refresh interval in clk_i cycles (>= 2).
- MAX_OWED_P, 8, maximum postponed refreshes (1..2^OWED_WIDTH_P-1).
- OWED_WIDTH_P, 4, width of owed_o.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous active-high reset
- count_i  input  CNT_WIDTH_P  current value from the interval counter
- ctr_up_o  output  1  counter increment enable
- ctr_reset_o  output  1  counter synchronous clear
- init_done_i  input  1  DDR init sequence complete (level)
- ref_req_o  output  1  at least one refresh owed
- ref_ack_i  input  1  one-cycle pulse: arbiter issued one REF
- ref_urgent_o  output  1  owed >= MAX_OWED_P-1
- owed_o  output  OWED_WIDTH_P  current owed-refresh count
- overflow_o  output  1  sticky: an interval elapsed while owed == MAX_OWED_P

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active-high. While reset_i is high:
  - state = IDLE, owed_r = 0, overflow_r = 0
  - all outputs read 0 except ctr_reset_o = 1.
- States: IDLE and RUN.
  - IDLE -> RUN when init_done_i = 1 (sampled at the clock edge).
  - RUN -> IDLE when init_done_i = 0. On this transition owed_r clears to 0; overflow_r is retained.
- Counter control (combinational from state and count_i):
  - ctr_up_o = (state == RUN).
  - tick = (state == RUN) && (count_i == TREFI_P-1).
  - ctr_reset_o = (state == IDLE) || tick.
  - Result: the counter cycles 0..TREFI_P-1, so one tick occurs every TREFI_P cycles in RUN. The first tick occurs TREFI_P cycles after entering RUN.
- Owed count update on each clock edge in RUN:
  - tick && !ack_v: owed_r + 1, saturating at MAX_OWED_P. If owed_r == MAX_OWED_P, owed_r is unchanged and overflow_r <= 1.
  - !tick && ack_v: owed_r - 1.
  - tick && ack_v: owed_r unchanged.
  - ack_v = ref_ack_i && (owed_r != 0). An ack with owed_r == 0 is ignored; no underflow.
- Outputs derived from registers (no combinational path from ref_ack_i):
  - ref_req_o = (owed_r != 0)
  - ref_urgent_o = (owed_r >= MAX_OWED_P-1)
  - owed_o = owed_r
  - overflow_o = overflow_r
- Latency: a tick at edge N is visible on owed_o/ref_req_o after edge N. An ack sampled at edge N drops ref_req_o after edge N when owed was 1.
- Handshake: ref_req_o is a level that stays high while refreshes are owed. Each ref_ack_i pulse retires exactly one refresh. Back-to-back acks are legal.
- In IDLE, ref_ack_i is ignored.
- Reset mid-operation: immediate return to the reset values. Any pending refreshes are discarded.

Optional Feature:
- Macro: REFRESH_SCHED_STATS_EN.
- Defined:
  - Adds output ref_total_o, 16 bits: number of accepted acks (ack_v) since reset, saturating at 16'hFFFF.
  - Adds output ovf_events_o, 8 bits: number of ticks dropped at saturation, saturating at 8'hFF.
  - Both counters clear on reset_i only.
- Not defined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan (TREFI_P=10, MAX_OWED_P=4, bench models counter_up):
- Reset, then init_done_i=1, no acks -> ctr_up_o=1; owed_o steps 1,2,3,4 at cycles 10,20,30,40 after entering RUN; ref_urgent_o rises when owed_o=3; overflow_o=1 after the tick at cycle 50; owed_o stays 4.
- owed_o=2, single ref_ack_i pulse -> owed_o=1 next cycle, ref_req_o stays 1; second pulse -> owed_o=0, ref_req_o=0.
- ref_ack_i pulsed on the exact tick cycle with owed_o=1 -> owed_o remains 1, ref_req_o stays 1.
- ref_ack_i pulsed with owed_o=0 -> owed_o stays 0, no wrap to 15.
- init_done_i dropped with owed_o=3 and overflow_o=1 -> next cycle owed_o=0, ctr_reset_o=1, ctr_up_o=0, overflow_o still 1; re-raise -> first tick 10 cycles later.
- reset_i asserted asynchronously mid-interval (count_i=6, owed_o=2) -> outputs go to reset values immediately, with no clock edge needed. With REFRESH_SCHED_STATS_EN defined, ref_total_o reads 0 after reset and 5 after 5 accepted acks.

Source files
------------

// File: rtl/refresh_scheduler.sv
// Periodic DDR refresh scheduler: turns tREFI ticks from an external interval
// counter into an owed-refresh count presented via req/ack. Optional stats: REFRESH_SCHED_STATS_EN.
module refresh_scheduler #(
    parameter int CNT_WIDTH_P  = 16,
    parameter int TREFI_P      = 7800,
    parameter int MAX_OWED_P   = 8,
    parameter int OWED_WIDTH_P = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [CNT_WIDTH_P-1:0]  count_i,
    output logic                    ctr_up_o,
    output logic                    ctr_reset_o,
    input  logic                    init_done_i,
    output logic                    ref_req_o,
    input  logic                    ref_ack_i,
    output logic                    ref_urgent_o,
    output logic [OWED_WIDTH_P-1:0] owed_o,
    output logic                    overflow_o
`ifdef REFRESH_SCHED_STATS_EN
    ,
    output logic [15:0]             ref_total_o,
    output logic [7:0]              ovf_events_o
`endif
);

    localparam logic [CNT_WIDTH_P-1:0]  LAST_CNT = CNT_WIDTH_P'(TREFI_P - 1);
    localparam logic [OWED_WIDTH_P-1:0] MAX_OWED = OWED_WIDTH_P'(MAX_OWED_P);
    localparam logic [OWED_WIDTH_P-1:0] URGENT   = OWED_WIDTH_P'(MAX_OWED_P - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [OWED_WIDTH_P-1:0] owed_r;
    logic                    overflow_r;
    logic                    tick;
    logic                    ack_v;
    logic                    stay_run;
    logic                    drop;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (init_done_i)  state_next = RUN;
            RUN:     if (!init_done_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign tick        = (state == RUN) && (count_i == LAST_CNT);
    assign ctr_up_o    = (state == RUN);
    assign ctr_reset_o = (state == IDLE) || tick;

    // Owed/overflow only move on edges where we remain in RUN; leaving RUN wins.
    assign stay_run = (state == RUN) && init_done_i;
    assign ack_v    = ref_ack_i && (owed_r != '0);
    assign drop     = stay_run && tick && !ack_v && (owed_r == MAX_OWED);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owed_r     <= '0;
            overflow_r <= 1'b0;
        end else if (state == RUN) begin
            if (!init_done_i) begin
                owed_r <= '0;
            end else if (tick && !ack_v) begin
                if (owed_r == MAX_OWED) overflow_r <= 1'b1;
                else                    owed_r     <= owed_r + 1'b1;
            end else if (!tick && ack_v) begin
                owed_r <= owed_r - 1'b1;
            end
        end
    end

    assign ref_req_o    = (owed_r != '0);
    // Qualified by RUN so the flag reads 0 under reset even when MAX_OWED_P is 1.
    assign ref_urgent_o = (state == RUN) && (owed_r >= URGENT);
    assign owed_o       = owed_r;
    assign overflow_o   = overflow_r;

`ifdef REFRESH_SCHED_STATS_EN
    logic [15:0] ref_total_r;
    logic [7:0]  ovf_events_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_total_r  <= '0;
            ovf_events_r <= '0;
        end else begin
            if (stay_run && ack_v && (ref_total_r != 16'hFFFF))
                ref_total_r <= ref_total_r + 16'd1;
            if (drop && (ovf_events_r != 8'hFF))
                ovf_events_r <= ovf_events_r + 8'd1;
        end
    end

    assign ref_total_o  = ref_total_r;
    assign ovf_events_o = ovf_events_r;
`endif

endmodule
